bank_data_pipe: RTL

//  Bank data-array access engine, directly downstream of the bank issue queue.

---
 rtl/bank_data_pipe.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/bank_data_pipe.sv
// -----------------------------------------------------------------------------
// bank_data_pipe
//
// Data-array access engine that sits directly behind the bank issue queue.
// It takes one issued request at a time and does the data SRAM access for
// both halves of the cacheline:
//   READ  : reads each enabled half from the SRAM and returns {half1, half0}.
//   WRITE : copies each enabled half from the write buffer into the SRAM.
//   NOP   : returns a response immediately, no array traffic.
// Exactly one response, tagged with rob_id/ch_id, is returned per request.
//
// State sequence: IDLE -> ACC0 -> ACC1 -> CAP -> RESP -> IDLE (NOP: IDLE -> RESP).
// A new request is only accepted in IDLE, so requests never overlap.
//
// Ports
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   iss_*                 issue-queue head: valid/ready handshake plus fields
//   sram_*                data SRAM port; read data returns one cycle after
//                         the read strobe
//   wbuf_rd_*             write-buffer read port; data returns one cycle after
//                         the strobe
//   resp_*                response to the ROB, valid/ready handshake
// -----------------------------------------------------------------------------
module bank_data_pipe #(
  parameter int DATA_W = 64,
  parameter int SWO_W  = 7
) (
  input  logic                clk_i,
  input  logic                rst_n_i,

  input  logic                iss_valid_i,
  output logic                iss_ready_o,
  input  logic [2:0]          iss_rob_id_i,
  input  logic [1:0]          iss_ch_id_i,
  input  logic [1:0]          iss_opcode_i,
  input  logic [SWO_W-1:0]    iss_swo_i,
  input  logic [7:0]          iss_wbuf_id_i,
  input  logic [1:0]          iss_cl0_state_i,
  input  logic [1:0]          iss_cl1_state_i,

  output logic                sram_en_o,
  output logic                sram_we_o,
  output logic [SWO_W:0]      sram_addr_o,
  output logic [DATA_W-1:0]   sram_wdata_o,
  input  logic [DATA_W-1:0]   sram_rdata_i,

  output logic                wbuf_rd_en_o,
  output logic [7:0]          wbuf_rd_id_o,
  output logic                wbuf_rd_half_o,
  input  logic [DATA_W-1:0]   wbuf_rd_data_i,

  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [2:0]          resp_rob_id_o,
  output logic [1:0]          resp_ch_id_o,
  output logic [2*DATA_W-1:0] resp_data_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_CAP,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;

  state_t             state;

  // Fields captured at the issue handshake.
  logic               is_read_q;
  logic               is_write_q;
  logic               en0_q;
  logic               en1_q;
  logic [SWO_W-1:0]   swo_q;
  logic [7:0]         wbuf_id_q;

  // Read data per half; stays zero for disabled halves, writes and NOPs.
  logic [DATA_W-1:0]  data0_q;
  logic [DATA_W-1:0]  data1_q;

  // Decode of the request at the head of the issue queue.
  logic               accept;
  logic               op_read;
  logic               op_write;
  logic               op_nop;
  logic               en0_in;
  logic               en1_in;

  assign accept   = iss_valid_i & iss_ready_o;
  assign op_read  = (iss_opcode_i == OP_READ);
  assign op_write = (iss_opcode_i == OP_WRITE);
  assign op_nop   = iss_opcode_i[1];

  // A read touches any valid half; a write only needs to move dirty halves.
  assign en0_in = op_read  ? (iss_cl0_state_i != 2'b00) :
                  op_write ? iss_cl0_state_i[1]         : 1'b0;
  assign en1_in = op_read  ? (iss_cl1_state_i != 2'b00) :
                  op_write ? iss_cl1_state_i[1]         : 1'b0;

  // Write-buffer data returns one cycle after its strobe, which is exactly
  // the cycle its SRAM write is issued, so it is forwarded straight through.
  assign sram_wdata_o = sram_we_o ? wbuf_rd_data_i : '0;

  assign resp_data_o  = {data1_q, data0_q};

  // NOTE: every register in this block uses non-blocking assignment so all
  // state and registered outputs update together at the clock edge, and the
  // case branches can read the pre-edge values of each other's state.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state          <= S_IDLE;
      iss_ready_o    <= 1'b1;
      sram_en_o      <= 1'b0;
      sram_we_o      <= 1'b0;
      sram_addr_o    <= '0;
      wbuf_rd_en_o   <= 1'b0;
      wbuf_rd_id_o   <= '0;
      wbuf_rd_half_o <= 1'b0;
      resp_valid_o   <= 1'b0;
      resp_rob_id_o  <= '0;
      resp_ch_id_o   <= '0;
      is_read_q      <= 1'b0;
      is_write_q     <= 1'b0;
      en0_q          <= 1'b0;
      en1_q          <= 1'b0;
      swo_q          <= '0;
      wbuf_id_q      <= '0;
      data0_q        <= '0;
      data1_q        <= '0;
    end else begin
      // NOTE: strobes are single-cycle pulses; defaulting them low here means
      // each state only has to state the strobes it raises.
      sram_en_o      <= 1'b0;
      sram_we_o      <= 1'b0;
      sram_addr_o    <= '0;
      wbuf_rd_en_o   <= 1'b0;
      wbuf_rd_id_o   <= '0;
      wbuf_rd_half_o <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            iss_ready_o   <= 1'b0;
            resp_rob_id_o <= iss_rob_id_i;
            resp_ch_id_o  <= iss_ch_id_i;
            is_read_q     <= op_read;
            is_write_q    <= op_write;
            en0_q         <= en0_in;
            en1_q         <= en1_in;
            swo_q         <= iss_swo_i;
            wbuf_id_q     <= iss_wbuf_id_i;
            data0_q       <= '0;
            data1_q       <= '0;
            if (op_nop) begin
              state        <= S_RESP;
              resp_valid_o <= 1'b1;
            end else begin
              state <= S_ACC0;
              // First access (half0) is issued for the ACC0 cycle.
              if (op_read && en0_in) begin
                sram_en_o   <= 1'b1;
                sram_addr_o <= {iss_swo_i, 1'b0};
              end
              if (op_write && en0_in) begin
                wbuf_rd_en_o   <= 1'b1;
                wbuf_rd_id_o   <= iss_wbuf_id_i;
                wbuf_rd_half_o <= 1'b0;
              end
            end
          end
        end

        S_ACC0: begin
          state <= S_ACC1;
          // Issued for ACC1: half1 read/fetch, and the half0 SRAM write that
          // consumes the write-buffer data fetched during ACC0.
          if (is_read_q && en1_q) begin
            sram_en_o   <= 1'b1;
            sram_addr_o <= {swo_q, 1'b1};
          end
          if (is_write_q && en1_q) begin
            wbuf_rd_en_o   <= 1'b1;
            wbuf_rd_id_o   <= wbuf_id_q;
            wbuf_rd_half_o <= 1'b1;
          end
          if (is_write_q && en0_q) begin
            sram_en_o   <= 1'b1;
            sram_we_o   <= 1'b1;
            sram_addr_o <= {swo_q, 1'b0};
          end
        end

        S_ACC1: begin
          state <= S_CAP;
          // Half0 read data is on sram_rdata_i during ACC1.
          if (is_read_q && en0_q) begin
            data0_q <= sram_rdata_i;
          end
          if (is_write_q && en1_q) begin
            sram_en_o   <= 1'b1;
            sram_we_o   <= 1'b1;
            sram_addr_o <= {swo_q, 1'b1};
          end
        end

        S_CAP: begin
          state        <= S_RESP;
          resp_valid_o <= 1'b1;
          if (is_read_q && en1_q) begin
            data1_q <= sram_rdata_i;
          end
        end

        S_RESP: begin
          // Response fields hold until the consumer takes them.
          if (resp_ready_i) begin
            state        <= S_IDLE;
            resp_valid_o <= 1'b0;
            iss_ready_o  <= 1'b1;
          end
        end

        default: begin
          state        <= S_IDLE;
          resp_valid_o <= 1'b0;
          iss_ready_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule
